spi_shift_engine: RTL
=====================

Name: spi_shift_engine

Overview:
- Parametrised full-duplex SPI master data path: serialises a TX word onto mosi and assembles a received word from miso.
- Supports word widths up to DATA_WIDTH, a per-frame programmable bit count, LSB/MSB-first ordering and all four CPOL/CPHA modes.
- Sits between the APB register slice (TX/RX data and control) and the SPI baud generator, which supplies one-cycle edge pulses.
- Adds frame-complete and abort reporting.

Parameters:
- DATA_WIDTH, 16, maximum frame length in bits (≥2).
- CNT_W, $clog2(DATA_WIDTH), width of frame_len and the bit counters.

Ports:
- PCLK  input  1  system clock
- PRESETn  input  1  asynchronous active-low reset
- ss  input  1  slave select from controller, active low
- cpol  input  1  clock polarity
- cpha  input  1  clock phase
- lsbfe  input  1  1 = LSB first
- frame_len  input  CNT_W  frame bits minus 1
- send_data  input  1  one-cycle load strobe
- tx_data  input  DATA_WIDTH  word to transmit, right-aligned
- flag_low  input  1  pulse one PCLK before SCLK falling edge
- flag_high  input  1  pulse one PCLK before SCLK rising edge
- miso  input  1  serial in
- mosi  output  1  serial out, registered
- rx_data  output  DATA_WIDTH  last completed received word, right-aligned
- rx_valid  output  1  one-cycle frame-complete pulse
- abort  output  1  one-cycle pulse when ss rises mid-frame
- busy  output  1  high in ARMED and XFER

Behaviour:
- Reset: asynchronous and active-low. State is IDLE; mosi, rx_data, rx_valid, abort, busy, shift registers and counters are all 0.
- mode_clk = cpol^cpha.
  - mode_clk=0: sample edge = flag_high, shift edge = flag_low.
  - mode_clk=1: sample edge = flag_low, shift edge = flag_high.
- Config latch: lsbfe, cpha and frame_len are latched at send_data. Changes during ARMED or XFER have no effect.
- frame_len ≥ DATA_WIDTH is clamped to DATA_WIDTH-1.
- Bit order: let L = latched frame_len and k = 0..L be the bit ordinal.
  - LSB-first: k-th transmitted bit is tx bit k; k-th sampled bit goes to rx bit k.
  - MSB-first: k-th transmitted bit is tx bit L-k; k-th sampled bit goes to rx bit L-k.
  - rx bits above L are 0.
- IDLE:
  - send_data loads tx_data into the TX register, latches config, clears the RX assembly register and both counters, and moves to ARMED.
  - If latched cpha=0, mosi takes bit ordinal 0 in the same edge. If cpha=1, mosi holds its value.
- ARMED:
  - A further send_data reloads data and config (last wins).
  - ss low → XFER. Edge pulses seen while ss is high are ignored.
- XFER, sample edge: capture miso at ordinal rx_cnt, then rx_cnt+1.
- XFER, shift edge with cpha=1: drive ordinal tx_cnt on mosi, then tx_cnt+1. Ignored once tx_cnt > L.
- XFER, shift edge with cpha=0: tx_cnt+1 and drive the new ordinal. Ignored once the new ordinal would exceed L; mosi then holds the last bit.
- Completion:
  - Trigger is the sample edge with rx_cnt==L.
  - In the next cycle: rx_data ← assembled word, rx_valid=1 for exactly one cycle, state → IDLE, busy=0.
  - Latency is 1 PCLK from the final sample pulse to rx_valid.
  - rx_data holds until the next completion.
- Abort:
  - Trigger is ss high during XFER before completion.
  - Next cycle: abort=1 for one cycle, state → IDLE, rx_data unchanged, no rx_valid. mosi holds.
  - ss high on the same cycle as the final sample pulse counts as completion, not abort.
- Other events:
  - send_data during XFER is ignored.
  - flag_low and flag_high together should not occur. If they do, both are processed (sample and shift are independent).
  - mosi does not change outside a shift edge or a load.

Test Plan:
- Mode 0 (cpol=0, cpha=0), MSB-first, frame_len=7, tx_data=0x00A5, slave drives 0x3C MSB-first -> mosi valid before first rising edge, sequence 1,0,1,0,0,1,0,1; rx_data=0x003C; single rx_valid pulse 1 cycle after 8th flag_high; busy falls with it.
- Mode 1 (cpol=0, cpha=1), LSB-first, frame_len=15, tx_data=0x8001, miso word 0xF00F -> mosi 1, fourteen 0s, 1, each driven on flag_high; rx_data=0xF00F; mode 2 repeat gives identical result.
- Short frame: frame_len=3, lsbfe=1, mode 3, tx_data=0xFFFB, miso 1,0,1,1 -> mosi 1,1,0,1; rx_data=0x000D; extra edge pulses after completion change nothing.
- Abort: mode 0, frame_len=7, raise ss after 3 sample pulses -> abort pulses once, rx_valid stays 0, rx_data keeps prior 0x003C, busy=0; next send_data starts cleanly from ordinal 0.
- Load rules: two send_data in ARMED (0x0011 then 0x0022, lsbfe change 0→1) -> frame sends 0x22 LSB-first; send_data during XFER leaves the transmitted bits unchanged.
- Reset: assert PRESETn low mid-XFER between PCLK edges -> mosi, rx_data, rx_valid, abort, busy go 0 immediately; after release, edge pulses with no send_data leave all outputs at 0.

Source files
------------

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: serialises a TX word onto mosi and assembles the
// received word from miso. Edge timing comes from the baud generator as
// one-cycle flag_low / flag_high pulses that arrive one PCLK ahead of the SCLK edge.
//
// state | meaning
// IDLE  | no frame pending; waiting for send_data
// ARMED | word and config loaded; waiting for ss to go low
// XFER  | shifting; edge pulses are processed until the last sample or until ss rises
module spi_shift_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  ss,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbfe,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  send_data,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  flag_low,
  input  logic                  flag_high,
  input  logic                  miso,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  abort,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_XFER} state_t;

  // The counters carry one extra bit because the TX ordinal can step one past the last bit.
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_asm_q, rx_asm_d, rx_data_q;
  logic [CNT_W-1:0]      len_q, len_d;
  logic                  lsbfe_q, cpha_q;
  logic [CNT_W:0]        rx_cnt_q, tx_cnt_q, tx_cnt_inc;
  logic                  mosi_q, rx_valid_q, abort_q, busy_q;
  logic                  mode_clk, sample_edge, shift_edge, last_sample;
  logic [CNT_W-1:0]      rx_bit, tx_bit_now, tx_bit_nxt, load_bit;

  // Maps a bit ordinal (the order of the bit on the wire) to a word bit position.
  function automatic logic [CNT_W-1:0] ord_to_bit(input logic [CNT_W-1:0] ord,
                                                  input logic lsb_first,
                                                  input logic [CNT_W-1:0] last);
    return lsb_first ? ord : last - ord;
  endfunction

  // Edge selection, bit positions and the clamped frame length.
  always_comb begin
    mode_clk    = cpol ^ cpha_q;
    sample_edge = mode_clk ? flag_low  : flag_high;
    shift_edge  = mode_clk ? flag_high : flag_low;
    tx_cnt_inc  = tx_cnt_q + CNT_ONE;
    last_sample = sample_edge && (rx_cnt_q == {1'b0, len_q});
    rx_bit      = ord_to_bit(rx_cnt_q[CNT_W-1:0], lsbfe_q, len_q);
    tx_bit_now  = ord_to_bit(tx_cnt_q[CNT_W-1:0], lsbfe_q, len_q);
    tx_bit_nxt  = ord_to_bit(tx_cnt_inc[CNT_W-1:0], lsbfe_q, len_q);
    len_d       = (int'(frame_len) > DATA_WIDTH-1) ? CNT_W'(DATA_WIDTH-1) : frame_len;
    load_bit    = lsbfe ? '0 : len_d;
  end

  // Receive assembly word with the current miso bit merged in on a sample edge.
  always_comb begin
    rx_asm_d = rx_asm_q;
    if (sample_edge) rx_asm_d[rx_bit] = miso;
  end

  // Frame FSM with the shift datapath and registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      rx_asm_q   <= '0;
      rx_data_q  <= '0;
      len_q      <= '0;
      lsbfe_q    <= 1'b0;
      cpha_q     <= 1'b0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_ARMED: begin
          if (send_data) begin
            tx_q     <= tx_data;
            lsbfe_q  <= lsbfe;
            cpha_q   <= cpha;
            len_q    <= len_d;
            rx_asm_q <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            // With cpha=0 the first bit must already be valid on mosi before the first SCLK edge.
            if (!cpha) mosi_q <= tx_data[load_bit];
            busy_q   <= 1'b1;
            state_q  <= S_ARMED;
          end else if (state_q == S_ARMED && !ss) begin
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          // A final sample that coincides with ss rising still completes the frame.
          if (ss && !last_sample) begin
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (sample_edge) begin
              rx_asm_q <= rx_asm_d;
              rx_cnt_q <= rx_cnt_q + CNT_ONE;
            end
            if (last_sample) begin
              rx_data_q  <= rx_asm_d;
              rx_valid_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end
            if (shift_edge) begin
              if (cpha_q) begin
                if (tx_cnt_q <= {1'b0, len_q}) begin
                  mosi_q   <= tx_q[tx_bit_now];
                  tx_cnt_q <= tx_cnt_inc;
                end
              end else if (tx_cnt_inc <= {1'b0, len_q}) begin
                mosi_q   <= tx_q[tx_bit_nxt];
                tx_cnt_q <= tx_cnt_inc;
              end
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign abort    = abort_q;
  assign busy     = busy_q;

endmodule
